i2c_slave_receiver: RTL and testbench

I2C_SLAVE_RECEIVER -- requirements
Module: i2c_slave_receiver

---
 rtl/i2c_slave_receiver.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_slave_receiver.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_receiver.sv
// I2C slave write receiver: synchronized bus sampling, START/STOP detection, address/data ACK, one-byte holding register.
// Build option: define GENERAL_CALL_EN to also accept the general-call address 7'h00 (write) as our own.
module i2c_slave_receiver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         WIDTH      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCL,
  input  logic             SDA_IN,
  output logic             SDA_OE,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             addr_match,
  output logic             read_req,
  output logic             busy
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

`ifdef GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  logic             scl_meta_r;
  logic             scl_sync_r;
  logic             scl_prev_r;
  logic             sda_meta_r;
  logic             sda_sync_r;
  logic             sda_prev_r;

  logic [2:0]       state_r;
  logic [2:0]       cnt_r;
  logic [WIDTH-2:0] shift_r;
  logic             oe_r;
  logic [WIDTH-1:0] dout_r;
  logic             valid_r;
  logic             match_r;
  logic             rreq_r;
  logic             busy_r;

  logic [2:0]       state_nx_s;
  logic [2:0]       cnt_nx_s;
  logic [WIDTH-2:0] shift_nx_s;
  logic             oe_nx_s;
  logic [WIDTH-1:0] dout_nx_s;
  logic             valid_nx_s;
  logic             match_nx_s;
  logic             rreq_nx_s;
  logic             busy_nx_s;

  logic             scl_rise_s;
  logic             scl_fall_s;
  logic             start_s;
  logic             stop_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] byte_s;

  // Address byte addressed to us with a write request (optionally general call too)
  function automatic logic is_write_target(input logic [7:0] b);
    logic hit;
    hit = (b[7:1] == SLAVE_ADDR) | (GC_EN & (b[7:1] == 7'h00));
    return hit & ~b[0];
  endfunction

  // Address byte addressed to us with a read request; handed over to the transmitter
  function automatic logic is_read_target(input logic [7:0] b);
    return (b[7:1] == SLAVE_ADDR) & b[0];
  endfunction

  // Two-stage synchronizers plus a history stage; reset to the idle-bus level
  always_ff @(posedge CLK) begin
    if (!RST) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_meta_r <= SCL;
      scl_sync_r <= scl_meta_r;
      scl_prev_r <= scl_sync_r;
      sda_meta_r <= SDA_IN;
      sda_sync_r <= sda_meta_r;
      sda_prev_r <= sda_sync_r;
    end
  end

  assign scl_rise_s = scl_sync_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_sync_r & scl_prev_r;
  assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
  assign last_bit_s = (cnt_r == 3'd7);
  assign byte_s     = {shift_r, sda_sync_r};

  // Next-state logic; STOP and START override whatever the FSM is doing
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    shift_nx_s = shift_r;
    oe_nx_s    = oe_r;
    dout_nx_s  = dout_r;
    match_nx_s = 1'b0;
    rreq_nx_s  = rreq_r;
    busy_nx_s  = busy_r;
    if (data_ack) begin
      valid_nx_s = 1'b0;
    end else begin
      valid_nx_s = valid_r;
    end

    if (stop_s) begin
      state_nx_s = ST_IDLE;
      cnt_nx_s   = 3'd0;
      oe_nx_s    = 1'b0;
      rreq_nx_s  = 1'b0;
      busy_nx_s  = 1'b0;
    end else if (start_s) begin
      state_nx_s = ST_ADDR;
      cnt_nx_s   = 3'd0;
      oe_nx_s    = 1'b0;
      rreq_nx_s  = 1'b0;
      busy_nx_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
          oe_nx_s    = 1'b0;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_nx_s = byte_s[WIDTH-2:0];
            cnt_nx_s   = cnt_r + 3'd1;
            if (last_bit_s) begin
              if (is_write_target(byte_s)) begin
                state_nx_s = ST_ADDR_ACK;
                match_nx_s = 1'b1;
              end else if (is_read_target(byte_s)) begin
                state_nx_s = ST_IGNORE;
                rreq_nx_s  = 1'b1;
              end else begin
                state_nx_s = ST_IGNORE;
              end
            end else begin
              state_nx_s = ST_ADDR;
            end
          end else begin
            state_nx_s = ST_ADDR;
          end
        end
        // First SCL fall after bit 8 opens the ACK slot, the next one closes it
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall_s) begin
            if (!oe_r) begin
              oe_nx_s = 1'b1;
            end else begin
              oe_nx_s    = 1'b0;
              state_nx_s = ST_DATA;
            end
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_DATA: begin
          if (scl_rise_s) begin
            shift_nx_s = byte_s[WIDTH-2:0];
            cnt_nx_s   = cnt_r + 3'd1;
            if (last_bit_s) begin
              // Overrun: the held byte is unread, so the new byte is NACKed and dropped
              if (!valid_r) begin
                dout_nx_s  = byte_s;
                valid_nx_s = 1'b1;
                state_nx_s = ST_DATA_ACK;
              end else begin
                state_nx_s = ST_IGNORE;
              end
            end else begin
              state_nx_s = ST_DATA;
            end
          end else begin
            state_nx_s = ST_DATA;
          end
        end
        ST_IGNORE: begin
          state_nx_s = ST_IGNORE;
          oe_nx_s    = 1'b0;
        end
        default: begin
          state_nx_s = ST_IDLE;
          oe_nx_s    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      shift_r <= '0;
      oe_r    <= 1'b0;
      dout_r  <= '0;
      valid_r <= 1'b0;
      match_r <= 1'b0;
      rreq_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      shift_r <= shift_nx_s;
      oe_r    <= oe_nx_s;
      dout_r  <= dout_nx_s;
      valid_r <= valid_nx_s;
      match_r <= match_nx_s;
      rreq_r  <= rreq_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign SDA_OE     = oe_r;
  assign data_out   = dout_r;
  assign data_valid = valid_r;
  assign addr_match = match_r;
  assign read_req   = rreq_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bench for i2c_slave_receiver: directed vector table, hand-written corner sequences, random transactions vs a byte-level model.
module tb_i2c_slave_receiver;

  localparam logic [6:0] OWN = 7'h42;
`ifdef GENERAL_CALL_EN
  localparam bit GC = 1'b1;
`else
  localparam bit GC = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       scl_drv;
  logic       sda_drv;
  logic       data_ack;
  logic       SDA_OE;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addr_match;
  logic       read_req;
  logic       busy;
  logic       sda_pad;

  assign sda_pad = sda_drv & ~SDA_OE;

  always #5 CLK = ~CLK;

  i2c_slave_receiver #(.SLAVE_ADDR(OWN), .WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SCL        (scl_drv),
    .SDA_IN     (sda_pad),
    .SDA_OE     (SDA_OE),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .addr_match (addr_match),
    .read_req   (read_req),
    .busy       (busy)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   match_cnt = 0;
  int   oe_viol = 0;
  int   valid_ack_cnt = 0;
  logic oe_prev = 1'b0;

  // Bus monitor: addr_match pulses, SDA_OE movement while SCL is high, valid seen alongside data_ack
  always @(negedge CLK) begin
    if (addr_match === 1'b1) match_cnt++;
    if (RST === 1'b1 && SDA_OE !== oe_prev && scl_drv === 1'b1) oe_viol++;
    if (data_ack === 1'b1 && data_valid === 1'b1) valid_ack_cnt++;
    oe_prev = SDA_OE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic qw();
    repeat (6) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1; data_ack = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; qw(); scl_drv = 1'b1; qw(); sda_drv = 1'b0; qw(); scl_drv = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; qw(); scl_drv = 1'b1; qw(); sda_drv = 1'b1; qw(); qw();
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; qw(); scl_drv = 1'b1; qw(); qw(); scl_drv = 1'b0; qw();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; qw(); scl_drv = 1'b1; qw();
    ack = ~sda_pad;
    qw(); scl_drv = 1'b0; qw();
  endtask

  task automatic pulse_data_ack();
    data_ack = 1'b1; @(negedge CLK); data_ack = 1'b0;
  endtask

  // Byte-level reference model: what the slave should do with each whole byte after a START
  logic       m_valid;
  logic [7:0] m_dout;
  logic       m_rreq;
  logic       m_busy;
  int         m_phase;  // 0 expect address, 1 accepting data, 2 ignoring, 3 idle
  int         m_match;

  task automatic m_reset();
    m_valid = 1'b0; m_dout = 8'h00; m_rreq = 1'b0; m_busy = 1'b0; m_phase = 3; m_match = 0;
  endtask

  task automatic m_start();
    m_phase = 0; m_rreq = 1'b0; m_busy = 1'b1;
  endtask

  task automatic m_stop();
    m_phase = 3; m_rreq = 1'b0; m_busy = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, output logic ack);
    int addr;
    int rw;
    ack = 1'b0;
    addr = int'(b) / 2;
    rw = int'(b) % 2;
    if (m_phase == 0) begin
      if (rw == 0 && (addr == int'(OWN) || (GC && addr == 0))) begin
        ack = 1'b1; m_match++; m_phase = 1;
      end else begin
        if (rw == 1 && addr == int'(OWN)) m_rreq = 1'b1;
        m_phase = 2;
      end
    end else if (m_phase == 1) begin
      if (!m_valid) begin
        m_valid = 1'b1; m_dout = b; ack = 1'b1;
      end else begin
        m_phase = 2;
      end
    end
  endtask

  typedef struct {
    string           name;
    int              n;
    logic [2:0][7:0] b;
    logic [2:0]      exp_ack;
    logic [7:0]      exp_dout;
    logic            exp_valid;
    logic            exp_rreq;
    int              exp_match;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    logic ack;
    int   base;
    do_reset();
    base = match_cnt;
    i2c_start();
    check({v.name, "_busy"}, busy, 1);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.b[i], ack);
      check($sformatf("%s_ack%0d", v.name, i), ack, v.exp_ack[i]);
    end
    check({v.name, "_dout"}, data_out, v.exp_dout);
    check({v.name, "_valid"}, data_valid, v.exp_valid);
    check({v.name, "_rreq"}, read_req, v.exp_rreq);
    check({v.name, "_match"}, match_cnt - base, v.exp_match);
    i2c_stop();
    check({v.name, "_busy_stop"}, busy, 0);
    check({v.name, "_rreq_stop"}, read_req, 0);
  endtask

  initial begin
    logic       ack;
    logic       mack;
    logic [7:0] b;
    int         base;
    int         nb;
    int         nbits;

    vecs[0] = '{"wr_a5",   2, {8'h00, 8'hA5, 8'h84}, 3'b011, 8'hA5, 1'b1, 1'b0, 1};
    vecs[1] = '{"other",   2, {8'h00, 8'h11, 8'h86}, 3'b000, 8'h00, 1'b0, 1'b0, 0};
    vecs[2] = '{"overrun", 3, {8'h02, 8'h01, 8'h84}, 3'b011, 8'h01, 1'b1, 1'b0, 1};
    vecs[3] = '{"read",    1, {8'h00, 8'h00, 8'h85}, 3'b000, 8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{"gcall",   2, {8'h00, 8'h55, 8'h00}, GC ? 3'b011 : 3'b000,
                GC ? 8'h55 : 8'h00, GC, 1'b0, GC ? 1 : 0};
    vecs[5] = '{"addr_only", 1, {8'h00, 8'h00, 8'h84}, 3'b001, 8'h00, 1'b0, 1'b0, 1};
    vecs[6] = '{"wr_7f",   3, {8'hFF, 8'h7F, 8'h84}, 3'b011, 8'h7F, 1'b1, 1'b0, 1};

    // Reset state
    RST = 1'b0; scl_drv = 1'b1; sda_drv = 1'b1; data_ack = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_oe", SDA_OE, 0);
    check("rst_dout", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_match", addr_match, 0);
    check("rst_rreq", read_req, 0);
    check("rst_busy", busy, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Partial byte cut by a repeated START
    do_reset();
    base = match_cnt;
    i2c_start();
    send_byte(8'h84, ack); check("rs_ack_a1", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    send_byte(8'h84, ack); check("rs_ack_a2", ack, 1);
    send_byte(8'h3C, ack); check("rs_ack_d", ack, 1);
    check("rs_dout", data_out, 8'h3C);
    check("rs_valid", data_valid, 1);
    check("rs_match", match_cnt - base, 2);
    i2c_stop();

    // Reset inside an ACK slot, then traffic without START must be ignored
    do_reset();
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h5A, ack); check("mr_ack_d", ack, 1);
    i2c_start();
    b = 8'h84;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; qw(); scl_drv = 1'b1; qw();
    check("mr_oe_before", SDA_OE, 1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("mr_oe_rst", SDA_OE, 0);
    check("mr_dout_rst", data_out, 0);
    check("mr_valid_rst", data_valid, 0);
    check("mr_busy_rst", busy, 0);
    RST = 1'b1;
    qw(); scl_drv = 1'b0; qw();
    send_byte(8'h84, ack); check("mr_ignored_ack", ack, 0);
    check("mr_ignored_valid", data_valid, 0);
    i2c_start();
    send_byte(8'h84, ack); check("mr_resume_ack", ack, 1);
    send_byte(8'h66, ack);
    check("mr_resume_dout", data_out, 8'h66);
    i2c_stop();

    // data_ack held across a byte load: the load wins, the next cycle clears
    do_reset();
    base = valid_ack_cnt;
    i2c_start();
    send_byte(8'h84, ack);
    data_ack = 1'b1;
    send_byte(8'hC3, ack);
    data_ack = 1'b0;
    @(negedge CLK);
    check("col_ack", ack, 1);
    check("col_seen", valid_ack_cnt > base, 1);
    check("col_valid", data_valid, 0);
    check("col_dout", data_out, 8'hC3);
    i2c_stop();

    // Random transactions against the byte-level model
    do_reset();
    m_reset();
    base = match_cnt;
    for (int t = 0; t < 20; t++) begin
      i2c_start(); m_start();
      check("rnd_busy", busy, m_busy);
      case ($urandom_range(0, 3))
        0: b = 8'h84;
        1: b = 8'h85;
        2: b = 8'h00;
        default: b = 8'($urandom_range(0, 255));
      endcase
      nb = $urandom_range(0, 3);
      for (int k = 0; k <= nb; k++) begin
        if (k > 0) b = 8'($urandom_range(0, 255));
        send_byte(b, ack);
        m_byte(b, mack);
        check($sformatf("rnd%0d_ack%0d", t, k), ack, mack);
        if ($urandom_range(0, 1) == 1) begin
          pulse_data_ack(); m_valid = 1'b0;
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        nbits = $urandom_range(1, 7);
        for (int k = 0; k < nbits; k++) send_bit(1'($urandom_range(0, 1)));
      end
      check($sformatf("rnd%0d_dout", t), data_out, m_dout);
      check($sformatf("rnd%0d_valid", t), data_valid, m_valid);
      check($sformatf("rnd%0d_rreq", t), read_req, m_rreq);
      if ($urandom_range(0, 2) != 0) begin
        i2c_stop(); m_stop();
        check($sformatf("rnd%0d_busy_stop", t), busy, m_busy);
        check($sformatf("rnd%0d_rreq_stop", t), read_req, m_rreq);
      end
    end
    i2c_stop(); m_stop();
    check("rnd_match", match_cnt - base, m_match);
    check("oe_stable_scl_high", oe_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
